// File: rtl/cmos_capture_rgb565.sv
// ---------------------------------------------------------------------------
// cmos_capture_rgb565
//
// Capture stage between the OV5640 DVP pins and the per-camera vip stage.
// Pairs bytes from the sensor bus into RGB565 pixels (high byte first). It
// delays vsync/href so they line up with the pixel output. It discards the
// first WAIT_FRAME frames after capture_start rises. It also generates
// xpos/ypos for every emitted pixel.
//
// Ports
//   clk              in   camera pixel clock; all registers on its rising edge
//   rst_n            in   asynchronous active-low reset
//   capture_start    in   enable level, asynchronous to clk (synchronised here)
//   cam_vsync        in   sensor vsync, active high
//   cam_href         in   sensor href, active high
//   cam_data[7:0]    in   sensor data bus
//   cmos_frame_vsync out  vsync delayed 2 clk, forced low outside RUN
//   cmos_frame_href  out  href delayed 2 clk, forced low outside RUN
//   cmos_frame_valid out  one-cycle pulse per assembled pixel
//   cmos_frame_data  out  RGB565 pixel {byte0, byte1}; holds when idle
//   xpos[10:0]       out  pixel index within line (saturates at 2047)
//   ypos[10:0]       out  line index within frame (saturates at 2047)
//   pix_err          out  one-cycle pulse when a line ends on an odd byte
// ---------------------------------------------------------------------------
module cmos_capture_rgb565 #(
    parameter int WAIT_FRAME  = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        capture_start,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    output logic        cmos_frame_vsync,
    output logic        cmos_frame_href,
    output logic        cmos_frame_valid,
    output logic [15:0] cmos_frame_data,
    output logic [10:0] xpos,
    output logic [10:0] ypos,
    output logic        pix_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SKIP = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [10:0] POS_MAX = 11'd2047;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_s1_vsync;
    logic                   r_s1_vsync_d;
    logic                   r_s1_href;
    logic [7:0]             r_s1_data;
    state_t                 r_state;
    logic [7:0]             r_frame_cnt;
    logic                   r_toggle;
    logic [7:0]             r_byte0;
    logic                   r_frame_vsync;
    logic                   r_frame_href;
    logic                   r_frame_valid;
    logic [15:0]            r_frame_data;
    logic [10:0]            r_xpos;
    logic [10:0]            r_ypos;
    logic                   r_pix_err;

    logic w_cs;
    logic w_vs_rise;
    logic w_last_skip;
    logic w_gate;
    logic w_pair;
    logic w_odd;
    logic w_href_next;
    logic w_vsync_next;

    assign w_cs      = r_cs_sync[SYNC_STAGES-1];
    assign w_vs_rise = r_s1_vsync & ~r_s1_vsync_d;

    // The vs_rise that completes the skip count enters RUN on the same edge,
    // so the gate already opens for that frame boundary.
    assign w_last_skip = (r_state == ST_SKIP) && w_vs_rise &&
                         (r_frame_cnt == 8'(WAIT_FRAME - 1));

    // Gate reflects the state being entered on this edge: outputs close on
    // the same edge that the FSM falls back to IDLE.
    assign w_gate = w_cs && ((r_state == ST_RUN) || w_last_skip);

    assign w_pair       = r_s1_href & r_toggle;
    // href already low but toggle still set: an unpaired byte is dropped.
    assign w_odd        = ~r_s1_href & r_toggle;
    assign w_href_next  = r_s1_href & w_gate;
    assign w_vsync_next = r_s1_vsync & w_gate;

    // capture_start synchroniser (the only clock-domain crossing).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_sync <= '0;
        end else begin
            r_cs_sync <= {r_cs_sync[SYNC_STAGES-2:0], capture_start};
        end
    end

    // Input register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vsync   <= 1'b0;
            r_s1_vsync_d <= 1'b0;
            r_s1_href    <= 1'b0;
            r_s1_data    <= 8'd0;
        end else begin
            r_s1_vsync   <= cam_vsync;
            r_s1_vsync_d <= r_s1_vsync;
            r_s1_href    <= cam_href;
            r_s1_data    <= cam_data;
        end
    end

    // Frame-skip FSM. A low cs wins over any other event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_frame_cnt <= 8'd0;
        end else if (!w_cs) begin
            r_state     <= ST_IDLE;
            r_frame_cnt <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_frame_cnt <= 8'd0;
                    r_state     <= ST_SKIP;
                end
                ST_SKIP: begin
                    if (w_vs_rise) begin
                        r_frame_cnt <= 8'(r_frame_cnt + 8'd1);
                        if (w_last_skip) begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Byte pairing and aligned, gated outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_toggle      <= 1'b0;
            r_byte0       <= 8'd0;
            r_frame_vsync <= 1'b0;
            r_frame_href  <= 1'b0;
            r_frame_valid <= 1'b0;
            r_frame_data  <= 16'd0;
            r_pix_err     <= 1'b0;
        end else begin
            r_toggle <= r_s1_href ? ~r_toggle : 1'b0;
            if (r_s1_href && !r_toggle) begin
                r_byte0 <= r_s1_data;
            end
            r_frame_vsync <= w_vsync_next;
            r_frame_href  <= w_href_next;
            r_frame_valid <= w_pair & w_gate;
            if (w_pair && w_gate) begin
                r_frame_data <= {r_byte0, r_s1_data};
            end
            r_pix_err <= w_odd & w_gate;
        end
    end

    // Position counters; both held at 0 whenever the gate is closed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xpos <= 11'd0;
            r_ypos <= 11'd0;
        end else if (!w_gate) begin
            r_xpos <= 11'd0;
            r_ypos <= 11'd0;
        end else begin
            if (r_frame_href && !w_href_next) begin
                r_xpos <= 11'd0;
                if (r_ypos != POS_MAX) begin
                    r_ypos <= r_ypos + 11'd1;
                end
            end else if (r_frame_valid && (r_xpos != POS_MAX)) begin
                r_xpos <= r_xpos + 11'd1;
            end
            // Frame start overrides a coincident line end.
            if (!r_frame_vsync && w_vsync_next) begin
                r_ypos <= 11'd0;
            end
        end
    end

    assign cmos_frame_vsync = r_frame_vsync;
    assign cmos_frame_href  = r_frame_href;
    assign cmos_frame_valid = r_frame_valid;
    assign cmos_frame_data  = r_frame_data;
    assign xpos             = r_xpos;
    assign ypos             = r_ypos;
    assign pix_err          = r_pix_err;

endmodule

// File: tb/tb_cmos_capture_rgb565.sv
// Directed bench for cmos_capture_rgb565 with WAIT_FRAME=2, SYNC_STAGES=2.
// Frames are driven as four lines followed by a vsync pulse; a negedge
// monitor pops the expected {ypos, xpos, data} for every valid pixel.
module tb_cmos_capture_rgb565;

  logic        clk;
  logic        rst_n;
  logic        capture_start;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        cmos_frame_vsync;
  logic        cmos_frame_href;
  logic        cmos_frame_valid;
  logic [15:0] cmos_frame_data;
  logic [10:0] xpos;
  logic [10:0] ypos;
  logic        pix_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_perr   = 0;
  int base_v;
  int base_e;
  bit mon_en   = 1'b1;
  logic prev_href = 1'b0;
  logic [37:0] mon_e;
  logic [37:0] exp_q[$];

  cmos_capture_rgb565 #(
    .WAIT_FRAME (2),
    .SYNC_STAGES(2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .capture_start   (capture_start),
    .cam_vsync       (cam_vsync),
    .cam_href        (cam_href),
    .cam_data        (cam_data),
    .cmos_frame_vsync(cmos_frame_vsync),
    .cmos_frame_href (cmos_frame_href),
    .cmos_frame_valid(cmos_frame_valid),
    .cmos_frame_data (cmos_frame_data),
    .xpos            (xpos),
    .ypos            (ypos),
    .pix_err         (pix_err)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [41:0] all_outs();
    return {cmos_frame_vsync, cmos_frame_href, cmos_frame_valid, cmos_frame_data,
            xpos, ypos, pix_err};
  endfunction

  function automatic logic [7:0] bval(input int seed, input int i);
    int v;
    v = seed * 37 + i * 13 + 5;
    return v[7:0];
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (cmos_frame_valid) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("pixel", {26'd0, ypos, xpos, cmos_frame_data}, {26'd0, mon_e});
        end
      end
      if (pix_err) begin
        n_perr++;
        check("perr_align", {62'd0, prev_href, cmos_frame_href}, 64'd2);
      end
    end
    prev_href = cmos_frame_href;
  end

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cam_href = 1'b0;
      cam_data = 8'd0;
    end
  endtask

  task automatic send_line(input int nbytes, input int seed, input int line_y, input bit expect_px);
    logic [10:0] xe;
    if (expect_px) begin
      for (int k = 0; k < nbytes / 2; k++) begin
        xe = (k > 2047) ? 11'd2047 : 11'(k);
        exp_q.push_back({11'(line_y), xe, bval(seed, 2 * k), bval(seed, 2 * k + 1)});
      end
    end
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk);
      cam_href = 1'b1;
      cam_data = bval(seed, i);
    end
    idle(5);
  endtask

  task automatic vsync_pulse();
    @(negedge clk);
    cam_vsync = 1'b1;
    repeat (3) @(negedge clk);
    cam_vsync = 1'b0;
    idle(4);
  endtask

  task automatic send_frame(input int seed, input bit expect_px);
    for (int l = 0; l < 4; l++) begin
      send_line(8, seed + l, l, expect_px);
    end
    vsync_pulse();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n         = 1'b0;
    capture_start = 1'b0;
    cam_vsync     = 1'b0;
    cam_href      = 1'b0;
    cam_data      = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(all_outs()), 64'd0);
    rst_n = 1'b1;
    capture_start = 1'b1;
    idle(5);

    // T1: two frames skipped, two frames captured.
    base_v = n_valid;
    send_frame(10, 1'b0);
    send_frame(20, 1'b0);
    check("t1_skip_no_valid", 64'(n_valid - base_v), 64'd0);
    send_frame(30, 1'b1);
    send_frame(40, 1'b1);
    check("t1_valid_count", 64'(n_valid - base_v), 64'd32);
    check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

    // T2: 0xF8,0x1F -> 0xF81F two clocks after 0x1F is on the pins.
    exp_q.push_back({11'd0, 11'd0, 16'hF81F});
    @(negedge clk); cam_href = 1'b1; cam_data = 8'hF8;
    @(negedge clk);
    check("t2_href_lag", 64'(cmos_frame_href), 64'd0);
    cam_data = 8'h1F;
    @(negedge clk);
    check("t2_valid_early", 64'(cmos_frame_valid), 64'd0);
    check("t2_href_align", 64'(cmos_frame_href), 64'd1);
    cam_href = 1'b0; cam_data = 8'd0;
    @(negedge clk);
    check("t2_valid", 64'(cmos_frame_valid), 64'd1);
    check("t2_data", 64'(cmos_frame_data), 64'hF81F);
    @(negedge clk);
    check("t2_valid_pulse", 64'(cmos_frame_valid), 64'd0);
    idle(4);

    // T3: odd line of 7 bytes, then a normal line.
    base_v = n_valid;
    base_e = n_perr;
    send_line(7, 50, 1, 1'b1);
    check("t3_valid_count", 64'(n_valid - base_v), 64'd3);
    check("t3_perr_count", 64'(n_perr - base_e), 64'd1);
    check("t3_xpos_reset", 64'(xpos), 64'd0);
    send_line(8, 60, 2, 1'b1);
    check("t3_next_line_count", 64'(n_valid - base_v), 64'd7);
    check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

    // T6: 2100-pixel line, xpos saturates at 2047.
    base_v = n_valid;
    send_line(4200, 70, 3, 1'b1);
    check("t6_valid_count", 64'(n_valid - base_v), 64'd2100);
    check("t6_xpos_reset", 64'(xpos), 64'd0);
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    // T4: drop capture_start mid-line, outputs close on the 3rd edge.
    mon_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); cam_href = 1'b1; cam_data = bval(80, i);
    end
    capture_start = 1'b0;
    @(negedge clk); cam_data = bval(80, 10);
    @(negedge clk); cam_data = bval(80, 11);
    check("t4_href_before_gate", 64'(cmos_frame_href), 64'd1);
    @(negedge clk); cam_data = bval(80, 12);
    check("t4_gated_outputs", {22'd0, cmos_frame_vsync, cmos_frame_href, cmos_frame_valid,
                               xpos, ypos, pix_err}, 64'd0);
    mon_en = 1'b1;
    for (int i = 13; i < 20; i++) begin
      @(negedge clk); cam_data = bval(80, i);
    end
    idle(5);
    check("t4_href_low", 64'(cmos_frame_href), 64'd0);
    capture_start = 1'b1;
    idle(5);
    base_v = n_valid;
    send_frame(90, 1'b0);
    send_frame(100, 1'b0);
    check("t4_restart_skip", 64'(n_valid - base_v), 64'd0);
    send_frame(110, 1'b1);
    check("t4_restart_count", 64'(n_valid - base_v), 64'd16);

    // T5: asynchronous reset mid-line.
    mon_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); cam_href = 1'b1; cam_data = bval(120, i);
    end
    @(negedge clk); cam_data = bval(120, 6);
    check("t5_pre_reset_data", 64'(cmos_frame_data), {48'd0, bval(120, 2), bval(120, 3)});
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_reset", 64'(all_outs()), 64'd0);
    @(negedge clk); cam_href = 1'b0; cam_data = 8'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    idle(5);
    check("t5_after_release", 64'(all_outs()), 64'd0);
    base_v = n_valid;
    send_frame(130, 1'b0);
    send_frame(140, 1'b0);
    check("t5_idle_skip", 64'(n_valid - base_v), 64'd0);
    send_frame(150, 1'b1);
    check("t5_run_count", 64'(n_valid - base_v), 64'd16);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
